// File: rtl/tx_frame_scheduler_pkg.sv
// rtl/tx_frame_scheduler_pkg.sv - shared types, Ethernet constants and header helpers for the TX scheduler
package defines;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
    } address;

    localparam int ETH_HDR_BYTES   = 14;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAX_PAYLOAD = 1500;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LOAD,
        ST_HDR,
        ST_PAY,
        ST_IFG
    } tx_sched_state_e;

    // Header byte idx (0..13) of {dst, src, length}, most significant byte first.
    function automatic logic [7:0] hdr_byte(input address a, input logic [15:0] len,
                                            input logic [3:0] idx);
        logic [111:0] hdr;
        logic [111:0] shifted;
        hdr     = {a.dst, a.src, len};
        shifted = hdr >> (7'd104 - {idx, 3'b000});
        return shifted[7:0];
    endfunction

    function automatic logic [15:0] clamp_len(input logic [15:0] len, input int min_len,
                                              input int max_len);
        int l;
        l = {16'd0, len};
        if (l < min_len) begin
            l = min_len;
        end else if (l > max_len) begin
            l = max_len;
        end
        return l[15:0];
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// rtl/tx_frame_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    int            idx;
    logic [PW-1:0] idx_w;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = PW'(idx);
            if (!valid && req[idx_w]) begin
                gnt[idx_w] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - round-robin frame scheduler streaming Ethernet frames over an 8-bit stream
module tx_frame_scheduler
    import defines::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int MIN_LEN    = ETH_MIN_PAYLOAD,
    parameter int MAX_LEN    = ETH_MAX_PAYLOAD,
    parameter int IFG_CYCLES = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  address [NUM_REQ-1:0]     req_addr,
    input  logic [NUM_REQ-1:0][15:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     address_wr,
    output address                   header_addr,
    input  address                   tx_address,
    output logic [7:0]               m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     busy
);

    localparam int         PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_BYTES - 1);

    tx_sched_state_e state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]     len_q, len_d;
    logic [3:0]      hdr_cnt_q, hdr_cnt_d;
    logic [15:0]     pay_cnt_q, pay_cnt_d;
    logic [15:0]     ifg_cnt_q, ifg_cnt_d;

    logic [NUM_REQ-1:0] grant_d;
    logic               address_wr_d;
    address             header_addr_d;
    logic [7:0]         m_tdata_d;
    logic               m_tvalid_d;
    logic               m_tlast_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_valid;
    logic [PW-1:0]      win;
    logic               hs;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win = PW'(i);
            end
        end
    end

    assign hs   = m_tvalid && m_tready;
    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        len_d         = len_q;
        hdr_cnt_d     = hdr_cnt_q;
        pay_cnt_d     = pay_cnt_q;
        ifg_cnt_d     = ifg_cnt_q;
        grant_d       = '0;
        address_wr_d  = 1'b0;
        header_addr_d = header_addr;
        m_tdata_d     = m_tdata;
        m_tvalid_d    = m_tvalid;
        m_tlast_d     = m_tlast;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d       = ST_GRANT;
                    grant_d       = arb_gnt;
                    address_wr_d  = 1'b1;
                    header_addr_d = req_addr[win];
                    len_d         = clamp_len(req_len[win], MIN_LEN, MAX_LEN);
                    rr_ptr_d      = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                end
            end
            ST_GRANT: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // tx_address now holds the pair written during GRANT.
                state_d    = ST_HDR;
                hdr_cnt_d  = '0;
                m_tvalid_d = 1'b1;
                m_tlast_d  = 1'b0;
                m_tdata_d  = hdr_byte(tx_address, len_q, 4'd0);
            end
            ST_HDR: begin
                if (hs) begin
                    if (hdr_cnt_q == HDR_LAST) begin
                        state_d   = ST_PAY;
                        pay_cnt_d = '0;
                        m_tdata_d = 8'h00;
                        m_tlast_d = (len_q == 16'd1);
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                        m_tdata_d = hdr_byte(tx_address, len_q, hdr_cnt_q + 4'd1);
                    end
                end
            end
            ST_PAY: begin
                if (hs) begin
                    if (pay_cnt_q == len_q - 16'd1) begin
                        state_d    = ST_IFG;
                        ifg_cnt_d  = '0;
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        m_tdata_d  = 8'h00;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 16'd1;
                        m_tdata_d = pay_cnt_d[7:0];
                        m_tlast_d = (pay_cnt_d == len_q - 16'd1);
                    end
                end
            end
            ST_IFG: begin
                // Counts clock cycles regardless of m_tready.
                if (int'(ifg_cnt_q) + 1 >= IFG_CYCLES) begin
                    state_d   = ST_IDLE;
                    ifg_cnt_d = '0;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            len_q       <= '0;
            hdr_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            ifg_cnt_q   <= '0;
            grant       <= '0;
            address_wr  <= 1'b0;
            header_addr <= '0;
            m_tdata     <= 8'h00;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            len_q       <= len_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            grant       <= grant_d;
            address_wr  <= address_wr_d;
            header_addr <= header_addr_d;
            m_tdata     <= m_tdata_d;
            m_tvalid    <= m_tvalid_d;
            m_tlast     <= m_tlast_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - scoreboard bench for tx_frame_scheduler with three requesters
module tb_tx_frame_scheduler;
    import defines::*;

    localparam int NREQ = 3;
    localparam int IFG  = 12;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    address [NREQ-1:0]     req_addr;
    logic [NREQ-1:0][15:0] req_len;
    logic [NREQ-1:0]       grant;
    logic                  address_wr;
    address                header_addr;
    address                tx_address;
    logic [7:0]            m_tdata;
    logic                  m_tvalid;
    logic                  m_tready = 1'b1;
    logic                  m_tlast;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]      byte_q[$];
    int              exp_len_q[$];
    logic [NREQ-1:0] gnt_q[$];
    address          addr_q[$];

    bit         stall_mode = 1'b0;
    int         grants_seen = 0;
    int         bytes_in_frame = 0;
    int         cyc = 0;
    int         grant_cyc = 0;
    int         gap_cnt = 0;
    bit         in_frame = 1'b0;
    bit         in_gap = 1'b0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_bus = '0;

    tx_frame_scheduler #(
        .NUM_REQ    (NREQ),
        .MIN_LEN    (46),
        .MAX_LEN    (1500),
        .IFG_CYCLES (IFG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .grant       (grant),
        .address_wr  (address_wr),
        .header_addr (header_addr),
        .tx_address  (tx_address),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // External TX address register.
    always @(posedge clk) begin
        if (!rst_n)          tx_address <= '0;
        else if (address_wr) tx_address <= header_addr;
    end

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_address_wr"}, address_wr, 0);
        check({tag, "_header_addr"}, header_addr, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic push_frame(input address a, input logic [15:0] len);
        int         clen;
        logic [15:0] l16;
        clen = (len < 16'd46) ? 46 : ((len > 16'd1500) ? 1500 : int'(len));
        l16  = 16'(clen);
        for (int i = 0; i < 6; i++) byte_q.push_back({1'b0, a.dst[47-8*i -: 8]});
        for (int i = 0; i < 6; i++) byte_q.push_back({1'b0, a.src[47-8*i -: 8]});
        byte_q.push_back({1'b0, l16[15:8]});
        byte_q.push_back({1'b0, l16[7:0]});
        for (int p = 0; p < clen; p++) byte_q.push_back({(p == clen - 1), 8'(p)});
        exp_len_q.push_back(14 + clen);
    endtask

    task automatic push_expect(input int idx);
        gnt_q.push_back(NREQ'(1 << idx));
        addr_q.push_back(req_addr[idx]);
        push_frame(req_addr[idx], req_len[idx]);
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (grants_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("grant_seen", grants_seen >= target, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((byte_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_done", (byte_q.size() == 0) && !busy, 1);
        check("grant_q_empty", gnt_q.size(), 0);
    endtask

    task automatic run_frame(input int idx, input logic [15:0] len, input logic [NREQ-1:0] mask);
        int target;
        req_len[idx] = len;
        push_expect(idx);
        target = grants_seen + 1;
        req = mask;
        wait_grants(target, 50);
        req = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        byte_q.delete();
        exp_len_q.delete();
        gnt_q.delete();
        addr_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = stall_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Stream and grant monitor, sampling on the falling edge.
    initial forever begin
        logic [8:0]      eb;
        logic [NREQ-1:0] eg;
        address          ea;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            in_frame       = 1'b0;
            in_gap         = 1'b0;
            prev_stall     = 1'b0;
            bytes_in_frame = 0;
            gap_cnt        = 0;
        end else begin
            if (grant != 0 || address_wr) begin
                if (gnt_q.size() == 0) begin
                    check("grant_unexpected", {grant, address_wr}, 0);
                end else begin
                    eg = gnt_q.pop_front();
                    ea = addr_q.pop_front();
                    check("grant", grant, eg);
                    check("address_wr", address_wr, 1);
                    check("header_addr", header_addr, ea);
                    grants_seen++;
                    grant_cyc = cyc;
                end
            end
            if (prev_stall) check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_bus});
            if (in_frame) begin
                check("valid_cont", m_tvalid, 1);
            end else if (m_tvalid) begin
                check("grant_to_data", cyc - grant_cyc, 2);
                if (in_gap) check("ifg_gap", gap_cnt >= IFG, 1);
                in_frame       = 1'b1;
                in_gap         = 1'b0;
                bytes_in_frame = 0;
            end else if (in_gap) begin
                gap_cnt++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_bus   = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                bytes_in_frame++;
                if (byte_q.size() == 0) begin
                    check("byte_q_empty", byte_q.size(), 1);
                end else begin
                    eb = byte_q.pop_front();
                    check("stream_byte", {m_tlast, m_tdata}, eb);
                end
                if (m_tlast) begin
                    check("frame_len", bytes_in_frame,
                          (exp_len_q.size() != 0) ? exp_len_q.pop_front() : 0);
                    in_frame = 1'b0;
                    in_gap   = 1'b1;
                    gap_cnt  = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req_addr[0] = {48'h0A0B0C0D0E0F, 48'h112233445566};
        req_addr[1] = {48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6};
        req_addr[2] = {48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6};
        req_len     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        release_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("idle");

        // Single request, 78-byte frame.
        run_frame(0, 16'd64, 3'b001);
        wait_drain(300);

        // Length clamping, including payload wrap past 256 bytes.
        run_frame(0, 16'd10, 3'b001);
        wait_drain(300);
        run_frame(0, 16'd2000, 3'b001);
        wait_drain(3000);
        run_frame(1, 16'd0, 3'b010);
        wait_drain(300);
        run_frame(2, 16'hFFFF, 3'b100);
        wait_drain(3000);

        // Round-robin fairness from a fresh pointer.
        do_reset();
        release_reset();
        req_len[0] = 16'd50;
        req_len[1] = 16'd60;
        req_len[2] = 16'd70;
        for (int k = 0; k < 6; k++) push_expect(k % NREQ);
        n = grants_seen + 6;
        req = 3'b111;
        wait_grants(n, 2000);
        req = '0;
        wait_drain(1000);

        // Backpressure at about 30% ready duty.
        stall_mode = 1'b1;
        run_frame(0, 16'd100, 3'b001);
        wait_drain(3000);
        run_frame(2, 16'd300, 3'b100);
        wait_drain(6000);
        stall_mode = 1'b0;

        // Reset in the middle of the payload (byte 20 on the bus).
        run_frame(0, 16'd64, 3'b001);
        n = 0;
        while (!(in_frame && bytes_in_frame == 34) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("reached_pay20", in_frame && bytes_in_frame == 34, 1);
        do_reset();
        check_reset_outputs("rst_mid");
        release_reset();
        run_frame(0, 16'd64, 3'b011);
        wait_drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Transmit-side frame scheduler for the pattern-generator MAC path. It arbitrates round-robin among `NUM_REQ` frame requesters and loads the winner's source/destination MAC pair into the TX address register. It then streams one Ethernet frame over an 8-bit AXI4-Stream master: a 14-byte header (dst, src, length), followed by an incrementing-byte payload and an inter-frame gap.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (≥1).
- `MIN_LEN`, default 46: minimum payload bytes; shorter requests are padded up to it.
- `MAX_LEN`, default 1500: maximum payload bytes; longer requests are clamped to it.
- `IFG_CYCLES`, default 12: idle cycles after `tlast` before the next arbitration.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `req` in `NUM_REQ`: per-requester frame request, level.
- `req_addr` in `NUM_REQ` × `address`: per-requester {dst,src} MAC pair.
- `req_len` in `NUM_REQ` × 16: per-requester payload length in bytes.
- `grant` out `NUM_REQ`: one-hot, one-cycle acceptance pulse.
- `address_wr` out 1: write strobe to the TX address register.
- `header_addr` out `address`: data to the TX address register.
- `tx_address` in `address`: registered address read back from the TX address register.
- `m_tdata` out 8: stream byte.
- `m_tvalid` out 1: stream valid.
- `m_tready` in 1: stream ready.
- `m_tlast` out 1: final byte of the frame.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → GRANT → LOAD → HDR → PAY → IFG → IDLE.
- **IDLE:** if any `req` bit is high, select a winner by round-robin. Search starts at `rr_ptr` and wraps. Go to GRANT. Otherwise stay in IDLE.
- **GRANT** (one cycle):
  - `grant[w]`=1 and `address_wr`=1.
  - `header_addr`=`req_addr[w]`.
  - Latch the clamped length `len_q` = max(`MIN_LEN`, min(`MAX_LEN`, `req_len[w]`)).
  - Set `rr_ptr` = (w+1) mod `NUM_REQ`.
- **LOAD** (one cycle): wait for `tx_address` to reflect the write.
- **HDR:** 14 bytes, index `hdr_cnt` 0..13.
  - Bytes 0–5: `tx_address.dst`, MSB byte first.
  - Bytes 6–11: `tx_address.src`, MSB byte first.
  - Bytes 12–13: `len_q[15:8]`, then `len_q[7:0]`.
- **PAY:** `len_q` bytes, with `m_tdata` = `pay_cnt[7:0]` and `pay_cnt` running 0..`len_q`-1. `m_tlast`=1 on byte `len_q`-1.
- **IFG:** count `IFG_CYCLES` cycles with `m_tvalid`=0, then return to IDLE.
- Counters advance only on a handshake (`m_tvalid` && `m_tready`).
- `req` changes outside the IDLE evaluation cycle are ignored. A request is never queued.
- `grant` is the only acknowledgment. A requester holding `req` high after its grant re-competes on the next IDLE.

## Timing
- Reset values: `grant`=0, `address_wr`=0, `header_addr`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `busy`=0, `rr_ptr`=0, all counters 0, state=IDLE.
- Latency: `req` seen in IDLE at cycle 0 → `grant`/`address_wr` at cycle 1 → LOAD at cycle 2 → first header byte valid at cycle 3.
- AXI rule: once `m_tvalid`=1, `m_tdata`/`m_tlast` hold stable until the handshake. `m_tvalid` stays continuously high from header byte 0 through the `tlast` handshake.
- Frame length on the wire is 14+`len_q` bytes. Minimum frame is 60 bytes, maximum is 1514.
- Boundary conditions:
  - `req_len`=0 → 46-byte payload, length field 0x002E.
  - `req_len`=0xFFFF → 1500-byte payload, length field 0x05DC.
  - Payload data wraps 0xFF→0x00 every 256 bytes.
- Simultaneous requests: exactly one grant, chosen by `rr_ptr` order. With all requesters permanently active, grants rotate in strict order.
- Reset mid-frame: the next edge forces IDLE and all outputs to reset values. No `tlast` is emitted. The downstream sees a truncated frame, which is acceptable.
- `m_tready` low during IFG has no effect. The IFG counts clock cycles, not handshakes.

## Structure
- Package `defines`:
  - Existing `address` typedef with fields `dst`, `src`, 48 bits each.
  - New constants `ETH_HDR_BYTES`=14, `ETH_MIN_PAYLOAD`=46, `ETH_MAX_PAYLOAD`=1500.
  - New FSM state enum `tx_sched_state_e`.
- One sub-module, `rr_arbiter` (parameter `N`; inputs `req` and `ptr`; outputs one-hot `gnt` and `valid`). It is purely combinational and reused by the scheduler.
- The top instantiates `rr_arbiter` and holds the FSM, counters, and output registers. The address register itself stays external.

## Test plan
1. **Single request:** `req[0]` high, dst=0x0A0B0C0D0E0F, src=0x112233445566, len=64.
   - Expect `address_wr` once, then 78 bytes.
   - Header is 0A..0F, 11..66, 00 40; payload is 00..3F; `tlast` on byte 77.
2. **Length clamping:**
   - len=10 → length field 00 2E, 60 bytes total.
   - len=2000 → length field 05 DC, 1514 bytes total, payload wraps at byte 256.
3. **Round-robin fairness:** `NUM_REQ`=3, all `req` held high for 6 frames.
   - Expect grant order 0,1,2,0,1,2.
   - Each frame is separated by ≥12 cycles with `m_tvalid`=0.
4. **Backpressure:** random `m_tready` at 30% duty.
   - `m_tdata`/`m_tlast` stable while stalled.
   - Byte sequence identical to the no-stall run.
5. **Reset mid-payload:** assert `rst_n`=0 at payload byte 20.
   - Next cycle: all outputs 0, `busy`=0.
   - After release, a new request produces a complete, correct frame with `rr_ptr` restarted at 0.
